// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor (a - b), LSB first.
// One full-subtractor cell plus a borrow flip-flop; one bit per clock.
// Results appear with a one-cycle done pulse WIDTH cycles after accept.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg;
  // Holds the WIDTH-1 difference bits produced so far; the final bit
  // comes straight from the cell on the completion edge.
  logic [WIDTH-2:0] sr_reg;
  logic [WIDTH-2:0] sr_shift;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             done_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow_reg;
`endif

  logic cell_x, cell_y, cell_bin, cell_d, cell_b;
  logic accept, last_bit, finish;

  // Single one-bit subtractor cell fed from the operand LSBs and borrow flop.
  always_comb begin
    cell_x   = sa_reg[0];
    cell_y   = sb_reg[0];
    cell_bin = borrow_reg;
    cell_d   = cell_x ^ cell_y ^ cell_bin;
    cell_b   = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_bin);
  end

  assign accept   = (state_reg == IDLE) && start;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign finish   = (state_reg == SHIFT) && last_bit;

  // Result shift register: new bit enters at the top, older bits move down.
  generate
    for (genvar gi = 0; gi < WIDTH - 2; gi++) begin : g_sr_shift
      assign sr_shift[gi] = sr_reg[gi+1];
    end
  endgenerate
  assign sr_shift[WIDTH-2] = cell_d;

  // Next-state logic: accept in IDLE, return to IDLE after the last bit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath: load operands on accept, shift one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg     <= '0;
      sb_reg     <= '0;
      sr_reg     <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      sa_reg     <= a;
      sb_reg     <= b;
      sr_reg     <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == SHIFT) begin
      sa_reg     <= {1'b0, sa_reg[WIDTH-1:1]};
      sb_reg     <= {1'b0, sb_reg[WIDTH-1:1]};
      sr_reg     <= sr_shift;
      borrow_reg <= cell_b;
      cnt_reg    <= last_bit ? '0 : cnt_reg + 1'b1;
    end
  end

  // Result registers: updated only on the completion edge, so partial
  // shift values never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg       <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= finish;
      if (finish) begin
        diff_reg       <= {cell_d, sr_reg};
        borrow_out_reg <= cell_b;
`ifdef SERIAL_SUB_OVF_EN
        // On the last bit the cell inputs are exactly the operand sign bits.
        overflow_reg   <= (cell_x ^ cell_y) & (cell_d ^ cell_x);
`endif
      end
    end
  end

  assign busy       = (state_reg == SHIFT);
  assign done       = done_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow   = overflow_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor
// (WIDTH=8). Overflow cases are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow_out;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called right after the accept edge; waits (bounded) for done.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
      checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`endif
    end
    $display("reset: idle 5 cycles checked");
  endtask

  task automatic test_basic;
    int cyc, bcyc;
    start_op(8'h05, 8'h03);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_accept: got %b want 1", busy); end
    wait_done(cyc, bcyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    checks++; if (bcyc != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bcyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff: got %h want 02", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", borrow_out); end
    $display("op a=05 b=03 diff=%h borrow=%b latency=%0d", diff, borrow_out, cyc);
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff_hold: got %h want 02", diff); end
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    start_op(8'h03, 8'h05);
    wait_done(cyc, bcyc);
    checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL b2b_diff1: got %h want fe", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL b2b_borrow1: got %b want 1", borrow_out); end
    $display("op a=03 b=05 diff=%h borrow=%b latency=%0d", diff, borrow_out, cyc);
    // Start issued in the done cycle must be accepted.
    start_op(8'hFF, 8'hFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low: got %b want 0", done); end
    checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL b2b_diff_hold: got %h want fe", diff); end
    wait_done(cyc, bcyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL b2b_diff2: got %h want 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL b2b_borrow2: got %b want 0", borrow_out); end
    $display("op a=ff b=ff diff=%h borrow=%b latency=%0d", diff, borrow_out, cyc);
    tick();
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int first = 0;
    start_op(8'h00, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin start = 1'b1; a = 8'h10; b = 8'h01; end
      if (k == 4) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = k;
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    checks++; if (first != 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", first); end
    checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL ignore_diff: got %h want ff", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL ignore_borrow: got %b want 1", borrow_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b want 0", busy); end
    $display("op a=00 b=01 (start in SHIFT) diff=%h borrow=%b dones=%0d", diff, borrow_out, dones);
  endtask

  task automatic test_reset_abort;
    int cyc, bcyc;
    int dones = 0;
    start_op(8'hAA, 8'h55);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL abort_diff: got %h want 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL abort_borrow: got %b want 0", borrow_out); end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    $display("op a=aa b=55 aborted by rst, dones=%0d", dones);
    start_op(8'hAA, 8'h55);
    wait_done(cyc, bcyc);
    checks++; if (diff !== 8'h55) begin errors++; $display("FAIL abort_retry_diff: got %h want 55", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL abort_retry_borrow: got %b want 0", borrow_out); end
    $display("op a=aa b=55 diff=%h borrow=%b latency=%0d", diff, borrow_out, cyc);
    tick();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow;
    int cyc, bcyc;
    start_op(8'h80, 8'h01);
    wait_done(cyc, bcyc);
    checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL ovf1_diff: got %h want 7f", diff); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf1_flag: got %b want 1", overflow); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL ovf1_borrow: got %b want 0", borrow_out); end
    $display("op a=80 b=01 diff=%h borrow=%b ovf=%b", diff, borrow_out, overflow);
    tick();
    start_op(8'h7F, 8'h01);
    wait_done(cyc, bcyc);
    checks++; if (diff !== 8'h7E) begin errors++; $display("FAIL ovf2_diff: got %h want 7e", diff); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf2_flag: got %b want 0", overflow); end
    $display("op a=7f b=01 diff=%h borrow=%b ovf=%b", diff, borrow_out, overflow);
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
